// File: rtl/axis_udp_pkg.sv
// Shared types and helpers for the AXIS frame arbiter.
package axis_udp_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } arb_state_t;

  // Largest port count the rotate helper supports.
  localparam int RR_MAX_PORTS = 16;

  // Round-robin pick: first set bit of req scanning last+1, last+2, ... (mod n).
  // Returns 0 when req is empty; callers qualify with |req.
  function automatic int rr_next(input logic [RR_MAX_PORTS-1:0] req,
                                 input int last,
                                 input int n);
    int   pick;
    int   cand;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= RR_MAX_PORTS; k++) begin
      cand = (last + k) % n;
      if ((k <= n) && !found && (|(req & (RR_MAX_PORTS'(1) << cand)))) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: request vector plus previous winner in,
// next winner index and "any request" flag out.
module rr_arbiter
  import axis_udp_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  localparam int PORT_IDX_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [PORT_IDX_WIDTH-1:0] last_grant,
  output logic [PORT_IDX_WIDTH-1:0] grant_idx,
  output logic                      grant_any
);

  logic [RR_MAX_PORTS-1:0] req_ext;
  int                      pick;

  // Widen the request to the helper's fixed width and rotate-scan it.
  always_comb begin
    req_ext = RR_MAX_PORTS'(req);
    pick    = rr_next(req_ext, int'(last_grant), NUM_PORTS);
  end

  assign grant_idx = PORT_IDX_WIDTH'(pick);
  assign grant_any = |req;

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-level round-robin arbiter: NUM_PORTS AXI-Stream sources share one
// master port. The grant is locked from a frame's first beat through tlast.
//
// Handshake: a beat moves on any edge where tvalid && tready are both high.
// A source holds tvalid and its payload until it sees tready; tready may be
// high or low independently of tvalid. Only the granted port ever sees
// tready, and it sees the filter's m_axis_tready unchanged (pure mux, no
// buffering), so no beat can be lost or duplicated in the arbiter.
// The grant_valid_o output mirrors the FSM state (1 = XFER).
module axis_frame_arbiter
  import axis_udp_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int AXIS_DATA_WIDTH = 64,
  localparam int PORT_IDX_WIDTH = $clog2(NUM_PORTS),
  localparam int STRB_WIDTH     = AXIS_DATA_WIDTH / 8
) (
  input  logic                            axis_clk,
  input  logic                            axis_s_rst,
  input  logic                            en,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*STRB_WIDTH-1:0] s_axis_tstrb,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic                            m_axis_tvalid,
  output logic [AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [STRB_WIDTH-1:0]           m_axis_tstrb,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [PORT_IDX_WIDTH-1:0]       grant_o,
  output logic                            grant_valid_o
);

  arb_state_t                state_q, state_d;
  logic [PORT_IDX_WIDTH-1:0] grant_q, grant_d;
  logic [PORT_IDX_WIDTH-1:0] last_grant_q, last_grant_d;
  logic                      grant_valid_q, grant_valid_d;

  logic [PORT_IDX_WIDTH-1:0] rr_idx;
  logic                      rr_any;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr (
    .req       (s_axis_tvalid),
    .last_grant(last_grant_q),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

  // State and grant registers; reset makes port 0 the first winner.
  always_ff @(posedge axis_clk) begin
    if (axis_s_rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_grant_q  <= PORT_IDX_WIDTH'(NUM_PORTS - 1);
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  // Next state: grab a port in IDLE when enabled, release it on the tlast beat.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    grant_valid_d = grant_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (en && rr_any) begin
          grant_d       = rr_idx;
          last_grant_d  = rr_idx;
          grant_valid_d = 1'b1;
          state_d       = ST_XFER;
        end
      end
      ST_XFER: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          grant_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: begin
        grant_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase
  end

  // Output mux: granted port passes straight through in XFER, all quiet in IDLE.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == ST_XFER) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant_q == PORT_IDX_WIDTH'(p)) begin
          m_axis_tvalid    = s_axis_tvalid[p];
          m_axis_tdata     = s_axis_tdata[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
          m_axis_tstrb     = s_axis_tstrb[p*STRB_WIDTH +: STRB_WIDTH];
          m_axis_tlast     = s_axis_tlast[p];
          s_axis_tready[p] = m_axis_tready;
        end
      end
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter (4 ports, 64-bit data).
module tb_axis_frame_arbiter;

  localparam int NP = 4;
  localparam int W  = 64;
  localparam int SW = W / 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               en;
  logic [NP-1:0]      s_tvalid;
  logic [NP*W-1:0]    s_tdata;
  logic [NP*SW-1:0]   s_tstrb;
  logic [NP-1:0]      s_tlast;
  logic [NP-1:0]      s_tready;
  logic               m_tvalid;
  logic [W-1:0]       m_tdata;
  logic [SW-1:0]      m_tstrb;
  logic               m_tlast;
  logic               m_tready;
  logic [1:0]         grant;
  logic               grant_valid;

  int errors = 0;
  int checks = 0;

  axis_frame_arbiter #(
    .NUM_PORTS      (NP),
    .AXIS_DATA_WIDTH(W)
  ) dut (
    .axis_clk     (clk),
    .axis_s_rst   (rst),
    .en           (en),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tdata (s_tdata),
    .s_axis_tstrb (s_tstrb),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tdata (m_tdata),
    .m_axis_tstrb (m_tstrb),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .grant_o      (grant),
    .grant_valid_o(grant_valid)
  );

  // checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // driver helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic drive(input int p, input logic v, input logic [63:0] d,
                       input logic [7:0] s, input logic l);
    s_tvalid[p]         = v;
    s_tdata[p*W +: W]   = d;
    s_tstrb[p*SW +: SW] = s;
    s_tlast[p]          = l;
  endtask

  function automatic logic [63:0] dat(input int p, input int f, input int b);
    return {32'hDA7A_0000, 8'(p), 8'(f), 16'(b)};
  endfunction

  function automatic logic [7:0] sb(input int p, input int b);
    logic [7:0] full;
    full = 8'hFF;
    return full >> ((p + b) % 8);
  endfunction

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "timeout");
  end

  int fr[NP];
  int order[6] = '{0, 1, 2, 3, 0, 1};
  int p;

  initial begin
    for (int i = 0; i < NP; i++) fr[i] = 0;

    // ---- reset with every port requesting
    rst      = 1'b1;
    en       = 1'b1;
    m_tready = 1'b1;
    s_tvalid = '1;
    s_tlast  = '0;
    s_tdata  = '1;
    s_tstrb  = '1;
    repeat (3) cyc();
    settle();
    chk("rst_s_tready", 64'(s_tready), 64'h0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'h0);
    chk("rst_grant_valid", 64'(grant_valid), 64'h0);
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_m_tdata", m_tdata, 64'h0);
    chk("rst_m_tstrb", 64'(m_tstrb), 64'h0);
    chk("rst_m_tlast", 64'(m_tlast), 64'h0);
    cyc();
    rst      = 1'b0;
    s_tvalid = '0;

    // ---- single port 2, 3-beat frame
    cyc();
    drive(2, 1'b1, dat(2, 0, 0), 8'hFF, 1'b0);
    settle();
    chk("single_idle_grant_valid", 64'(grant_valid), 64'h0);
    chk("single_idle_no_ready", 64'(s_tready), 64'h0);
    cyc();
    settle();
    chk("single_grant", 64'(grant), 64'h2);
    chk("single_grant_valid", 64'(grant_valid), 64'h1);
    chk("single_b0_tvalid", 64'(m_tvalid), 64'h1);
    chk("single_b0_tdata", m_tdata, dat(2, 0, 0));
    chk("single_b0_tstrb", 64'(m_tstrb), 64'hFF);
    chk("single_b0_ready", 64'(s_tready), 64'h4);
    cyc();
    drive(2, 1'b1, dat(2, 0, 1), 8'h0F, 1'b0);
    settle();
    chk("single_b1_tdata", m_tdata, dat(2, 0, 1));
    chk("single_b1_tstrb", 64'(m_tstrb), 64'h0F);
    chk("single_b1_tlast", 64'(m_tlast), 64'h0);
    cyc();
    drive(2, 1'b1, dat(2, 0, 2), 8'h3C, 1'b1);
    settle();
    chk("single_b2_tdata", m_tdata, dat(2, 0, 2));
    chk("single_b2_tstrb", 64'(m_tstrb), 64'h3C);
    chk("single_b2_tlast", 64'(m_tlast), 64'h1);
    chk("single_b2_grant_valid", 64'(grant_valid), 64'h1);
    cyc();
    drive(2, 1'b0, 64'h0, 8'h0, 1'b0);
    settle();
    chk("single_done_grant_valid", 64'(grant_valid), 64'h0);
    chk("single_done_m_tvalid", 64'(m_tvalid), 64'h0);
    chk("single_done_ready", 64'(s_tready), 64'h0);

    // ---- fairness: all ports streaming 2-beat frames, from reset
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NP; i++) drive(i, 1'b1, dat(i, 0, 0), sb(i, 0), 1'b0);
    for (int i = 0; i < 6; i++) begin
      p = order[i];
      settle();
      chk("fair_bubble_grant_valid", 64'(grant_valid), 64'h0);
      chk("fair_bubble_ready", 64'(s_tready), 64'h0);
      cyc();
      settle();
      chk("fair_grant", 64'(grant), 64'(p));
      chk("fair_b0_ready", 64'(s_tready), 64'(4'b0001 << p));
      chk("fair_b0_tdata", m_tdata, dat(p, fr[p], 0));
      chk("fair_b0_tstrb", 64'(m_tstrb), 64'(sb(p, 0)));
      cyc();
      drive(p, 1'b1, dat(p, fr[p], 1), sb(p, 1), 1'b1);
      settle();
      chk("fair_b1_tdata", m_tdata, dat(p, fr[p], 1));
      chk("fair_b1_tlast", 64'(m_tlast), 64'h1);
      chk("fair_b1_ready", 64'(s_tready), 64'(4'b0001 << p));
      cyc();
      fr[p] = fr[p] + 1;
      drive(p, 1'b1, dat(p, fr[p], 0), sb(p, 0), 1'b0);
    end

    // ---- backpressure 1010 on a port-1 frame
    for (int i = 0; i < NP; i++) drive(i, 1'b0, 64'h0, 8'h0, 1'b0);
    drive(1, 1'b1, dat(1, 9, 0), 8'hF0, 1'b0);
    settle();
    chk("bp_idle_grant_valid", 64'(grant_valid), 64'h0);
    cyc();
    settle();
    chk("bp_grant", 64'(grant), 64'h1);
    chk("bp_ready_hi0", 64'(s_tready), 64'h2);
    chk("bp_b0_tdata", m_tdata, dat(1, 9, 0));
    cyc();
    drive(1, 1'b1, dat(1, 9, 1), 8'h0F, 1'b1);
    m_tready = 1'b0;
    settle();
    chk("bp_ready_lo1", 64'(s_tready), 64'h0);
    chk("bp_stall_tvalid", 64'(m_tvalid), 64'h1);
    chk("bp_stall_tdata", m_tdata, dat(1, 9, 1));
    cyc();
    m_tready = 1'b1;
    settle();
    chk("bp_ready_hi2", 64'(s_tready), 64'h2);
    chk("bp_held_tdata", m_tdata, dat(1, 9, 1));
    chk("bp_held_grant_valid", 64'(grant_valid), 64'h1);
    cyc();
    m_tready = 1'b0;
    drive(1, 1'b0, 64'h0, 8'h0, 1'b0);
    settle();
    chk("bp_done_grant_valid", 64'(grant_valid), 64'h0);
    chk("bp_ready_lo3", 64'(s_tready), 64'h0);
    m_tready = 1'b1;

    // ---- en dropped during a 5-beat port-3 frame
    cyc();
    en = 1'b1;
    drive(3, 1'b1, dat(3, 0, 0), sb(3, 0), 1'b0);
    settle();
    chk("en_idle_grant_valid", 64'(grant_valid), 64'h0);
    cyc();
    settle();
    chk("en_grant", 64'(grant), 64'h3);
    chk("en_b0_tdata", m_tdata, dat(3, 0, 0));
    cyc();
    en = 1'b0;
    drive(0, 1'b1, dat(0, 7, 0), 8'hFF, 1'b1);
    for (int b = 1; b <= 4; b++) begin
      drive(3, 1'b1, dat(3, 0, b), sb(3, b), (b == 4));
      settle();
      chk("en_mid_grant_valid", 64'(grant_valid), 64'h1);
      chk("en_mid_grant", 64'(grant), 64'h3);
      chk("en_mid_tdata", m_tdata, dat(3, 0, b));
      chk("en_mid_ready", 64'(s_tready), 64'h8);
      cyc();
    end
    drive(3, 1'b0, 64'h0, 8'h0, 1'b0);
    settle();
    chk("en_off_grant_valid0", 64'(grant_valid), 64'h0);
    chk("en_off_ready0", 64'(s_tready), 64'h0);
    cyc();
    settle();
    chk("en_off_grant_valid1", 64'(grant_valid), 64'h0);
    chk("en_off_m_tvalid1", 64'(m_tvalid), 64'h0);
    cyc();
    en = 1'b1;
    settle();
    chk("en_on_grant_valid", 64'(grant_valid), 64'h0);
    cyc();
    settle();
    chk("en_on_grant", 64'(grant), 64'h0);
    chk("en_on_grant_valid1", 64'(grant_valid), 64'h1);
    chk("en_on_tlast", 64'(m_tlast), 64'h1);
    chk("en_on_tdata", m_tdata, dat(0, 7, 0));
    cyc();
    drive(0, 1'b0, 64'h0, 8'h0, 1'b0);
    settle();
    chk("en_single_done", 64'(grant_valid), 64'h0);

    // ---- reset at beat 2 of a port-1 frame
    cyc();
    drive(1, 1'b1, dat(1, 3, 0), sb(1, 0), 1'b0);
    settle();
    cyc();
    settle();
    chk("mrst_grant", 64'(grant), 64'h1);
    cyc();
    drive(1, 1'b1, dat(1, 3, 1), sb(1, 1), 1'b0);
    cyc();
    drive(1, 1'b1, dat(1, 3, 2), sb(1, 2), 1'b0);
    settle();
    chk("mrst_b2_tdata", m_tdata, dat(1, 3, 2));
    rst = 1'b1;
    cyc();
    settle();
    chk("mrst_grant_valid", 64'(grant_valid), 64'h0);
    chk("mrst_ready", 64'(s_tready), 64'h0);
    chk("mrst_m_tvalid", 64'(m_tvalid), 64'h0);
    chk("mrst_grant_cleared", 64'(grant), 64'h0);
    cyc();
    rst = 1'b0;
    drive(0, 1'b1, dat(0, 8, 0), sb(0, 0), 1'b0);
    drive(2, 1'b1, dat(2, 8, 0), sb(2, 0), 1'b0);
    settle();
    chk("mrst_release_idle", 64'(grant_valid), 64'h0);
    cyc();
    settle();
    chk("mrst_first_grant", 64'(grant), 64'h0);
    chk("mrst_first_ready", 64'(s_tready), 64'h1);
    chk("mrst_first_tdata", m_tdata, dat(0, 8, 0));

    // ---- report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
